// File: rtl/alu_cnt_dec_unit_pkg.sv
// rtl/alu_cnt_dec_unit_pkg.sv - shared opcodes and widths for the ALU/counter/decoder unit
package alu_cnt_dec_unit_pkg;

    localparam int ALU_W = 4;
    localparam int CNT_W = 3;

    typedef enum logic [2:0] {
        ADD = 3'b000,
        SUB = 3'b001,
        NOT = 3'b010,
        AND = 3'b011,
        OR  = 3'b100,
        XOR = 3'b101,
        SLT = 3'b110,
        EQ  = 3'b111
    } alu_op_t;

endpackage

// File: rtl/alu_cnt_dec_unit_if.sv
// rtl/alu_cnt_dec_unit_if.sv - operand, control and result bundle of the unit
interface alu_cnt_dec_unit_if;
    import alu_cnt_dec_unit_pkg::*;

    logic [2:0]       alu_fnselec;
    logic [ALU_W-1:0] alu_a;
    logic [ALU_W-1:0] alu_b;
    logic [ALU_W-1:0] alu_res;
    logic             alu_zero;
    logic             alu_overflow;
    logic             alu_carry;
    logic             counter_en;
    logic [CNT_W-1:0] dec_counter_out;
    logic [2:0]       x;
    logic             en;
    logic [7:0]       y_dec;

    modport master (
        output alu_fnselec, alu_a, alu_b, counter_en, x, en,
        input  alu_res, alu_zero, alu_overflow, alu_carry, dec_counter_out, y_dec
    );

    modport slave (
        input  alu_fnselec, alu_a, alu_b, counter_en, x, en,
        output alu_res, alu_zero, alu_overflow, alu_carry, dec_counter_out, y_dec
    );
endinterface

// File: rtl/alu_cnt_dec_unit_alu_4bit_core.sv
// rtl/alu_cnt_dec_unit_alu_4bit_core.sv - combinational 4-bit ALU datapath with carry/overflow
module alu_4bit_core
    import alu_cnt_dec_unit_pkg::*;
(
    input  logic [2:0]       op,
    input  logic [ALU_W-1:0] a,
    input  logic [ALU_W-1:0] b,
    output logic [ALU_W-1:0] res,
    output logic             carry,
    output logic             overflow
);

    logic [ALU_W:0] sum;
    logic [ALU_W:0] diff;

    // Subtraction is A + ~B + 1 so carry means "no borrow" (A >= B unsigned).
    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} + {1'b0, ~b} + {{ALU_W{1'b0}}, 1'b1};

    always_comb begin
        res      = '0;
        carry    = 1'b0;
        overflow = 1'b0;
        case (alu_op_t'(op))
            ADD: begin
                res      = sum[ALU_W-1:0];
                carry    = sum[ALU_W];
                overflow = (a[ALU_W-1] == b[ALU_W-1]) && (sum[ALU_W-1] != a[ALU_W-1]);
            end
            SUB: begin
                res      = diff[ALU_W-1:0];
                carry    = diff[ALU_W];
                overflow = (a[ALU_W-1] != b[ALU_W-1]) && (diff[ALU_W-1] != a[ALU_W-1]);
            end
            NOT:     res = ~a;
            AND:     res = a & b;
            OR:      res = a | b;
            XOR:     res = a ^ b;
            SLT:     res = {{(ALU_W-1){1'b0}}, ($signed(a) < $signed(b))};
            EQ:      res = {{(ALU_W-1){1'b0}}, (a == b)};
            default: res = '0;
        endcase
    end

endmodule

// File: rtl/alu_cnt_dec_unit.sv
// rtl/alu_cnt_dec_unit.sv - registered ALU, 3-bit down-counter and registered 3-to-8 decoder
module alu_cnt_dec_unit
    import alu_cnt_dec_unit_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    alu_cnt_dec_unit_if.slave bus
);

    logic [ALU_W-1:0] res_c;
    logic             carry_c;
    logic             overflow_c;

    alu_4bit_core u_core (
        .op       (bus.alu_fnselec),
        .a        (bus.alu_a),
        .b        (bus.alu_b),
        .res      (res_c),
        .carry    (carry_c),
        .overflow (overflow_c)
    );

    // Zero flag tracks the result being captured on this edge, not the previous one.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.alu_res         <= '0;
            bus.alu_zero        <= 1'b0;
            bus.alu_overflow    <= 1'b0;
            bus.alu_carry       <= 1'b0;
            bus.dec_counter_out <= '0;
            bus.y_dec           <= '0;
        end else begin
            bus.alu_res      <= res_c;
            bus.alu_zero     <= (res_c == '0);
            bus.alu_overflow <= overflow_c;
            bus.alu_carry    <= carry_c;
            if (bus.counter_en)
                bus.dec_counter_out <= bus.dec_counter_out - {{(CNT_W-1){1'b0}}, 1'b1};
            bus.y_dec <= bus.en ? (8'b0000_0001 << bus.x) : 8'b0000_0000;
        end
    end

endmodule

// File: tb/tb_alu_cnt_dec_unit.sv
// tb/tb_alu_cnt_dec_unit.sv - directed self-checking bench for alu_cnt_dec_unit
module tb_alu_cnt_dec_unit;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    alu_cnt_dec_unit_if bus ();

    alu_cnt_dec_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] op;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] res;
        logic       c;
        logic       v;
        logic       z;
    } alu_vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.alu_fnselec = 3'b000;
        bus.alu_a = 4'b1111;
        bus.alu_b = 4'b0001;
        bus.counter_en = 1'b1;
        bus.x = 3'b011;
        bus.en = 1'b1;
        tick();
        tick();
        total++;
        if (bus.alu_res !== 4'b0000 || bus.alu_zero !== 1'b0 || bus.alu_overflow !== 1'b0 ||
            bus.alu_carry !== 1'b0) begin
            bad++;
            $display("FAIL reset_alu: res=%b z=%b v=%b c=%b required 0000 0 0 0",
                     bus.alu_res, bus.alu_zero, bus.alu_overflow, bus.alu_carry);
        end
        total++;
        if (bus.dec_counter_out !== 3'b000) begin
            bad++;
            $display("FAIL reset_counter: got=%b required=000", bus.dec_counter_out);
        end
        total++;
        if (bus.y_dec !== 8'b0000_0000) begin
            bad++;
            $display("FAIL reset_decoder: got=%b required=00000000", bus.y_dec);
        end
        bus.counter_en = 1'b0;
        bus.en = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_alu_arith();
        alu_vec_t t [8];
        t[0] = '{3'b000, 4'b0111, 4'b0001, 4'b1000, 1'b0, 1'b1, 1'b0};
        t[1] = '{3'b000, 4'b1111, 4'b0001, 4'b0000, 1'b1, 1'b0, 1'b1};
        t[2] = '{3'b000, 4'b0011, 4'b0100, 4'b0111, 1'b0, 1'b0, 1'b0};
        t[3] = '{3'b000, 4'b1000, 4'b1000, 4'b0000, 1'b1, 1'b1, 1'b1};
        t[4] = '{3'b001, 4'b1000, 4'b0001, 4'b0111, 1'b1, 1'b1, 1'b0};
        t[5] = '{3'b001, 4'b0101, 4'b0101, 4'b0000, 1'b1, 1'b0, 1'b1};
        t[6] = '{3'b001, 4'b0001, 4'b0010, 4'b1111, 1'b0, 1'b0, 1'b0};
        t[7] = '{3'b001, 4'b0111, 4'b1111, 4'b1000, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 8; i++) begin
            bus.alu_fnselec = t[i].op;
            bus.alu_a = t[i].a;
            bus.alu_b = t[i].b;
            tick();
            total++;
            if ({bus.alu_res, bus.alu_carry, bus.alu_overflow, bus.alu_zero} !==
                {t[i].res, t[i].c, t[i].v, t[i].z}) begin
                bad++;
                $display("FAIL alu_arith[%0d] op=%b a=%b b=%b: res/c/v/z=%b/%b/%b/%b required %b/%b/%b/%b",
                         i, t[i].op, t[i].a, t[i].b, bus.alu_res, bus.alu_carry, bus.alu_overflow,
                         bus.alu_zero, t[i].res, t[i].c, t[i].v, t[i].z);
            end
        end
    endtask

    task automatic test_alu_logic_cmp();
        alu_vec_t t [11];
        t[0]  = '{3'b010, 4'b1010, 4'b0000, 4'b0101, 1'b0, 1'b0, 1'b0};
        t[1]  = '{3'b010, 4'b1111, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1};
        t[2]  = '{3'b011, 4'b1100, 4'b1010, 4'b1000, 1'b0, 1'b0, 1'b0};
        t[3]  = '{3'b100, 4'b1100, 4'b1010, 4'b1110, 1'b0, 1'b0, 1'b0};
        t[4]  = '{3'b101, 4'b1100, 4'b1010, 4'b0110, 1'b0, 1'b0, 1'b0};
        t[5]  = '{3'b101, 4'b0101, 4'b0101, 4'b0000, 1'b0, 1'b0, 1'b1};
        t[6]  = '{3'b110, 4'b1111, 4'b0001, 4'b0001, 1'b0, 1'b0, 1'b0};
        t[7]  = '{3'b110, 4'b0001, 4'b1111, 4'b0000, 1'b0, 1'b0, 1'b1};
        t[8]  = '{3'b110, 4'b0111, 4'b0111, 4'b0000, 1'b0, 1'b0, 1'b1};
        t[9]  = '{3'b111, 4'b0101, 4'b0101, 4'b0001, 1'b0, 1'b0, 1'b0};
        t[10] = '{3'b111, 4'b0101, 4'b0100, 4'b0000, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 11; i++) begin
            bus.alu_fnselec = t[i].op;
            bus.alu_a = t[i].a;
            bus.alu_b = t[i].b;
            tick();
            total++;
            if ({bus.alu_res, bus.alu_carry, bus.alu_overflow, bus.alu_zero} !==
                {t[i].res, t[i].c, t[i].v, t[i].z}) begin
                bad++;
                $display("FAIL alu_logic_cmp[%0d] op=%b a=%b b=%b: res/c/v/z=%b/%b/%b/%b required %b/%b/%b/%b",
                         i, t[i].op, t[i].a, t[i].b, bus.alu_res, bus.alu_carry, bus.alu_overflow,
                         bus.alu_zero, t[i].res, t[i].c, t[i].v, t[i].z);
            end
        end
    endtask

    task automatic test_counter();
        logic [2:0] exp_seq [8];
        logic [7:0] en_seq;
        logic [7:0] rst_seq;
        exp_seq = '{3'b000, 3'b111, 3'b110, 3'b101, 3'b101, 3'b101, 3'b100, 3'b000};
        en_seq  = 8'b0100_1110;
        rst_seq = 8'b1000_0001;
        for (int i = 0; i < 8; i++) begin
            rst = rst_seq[i];
            bus.counter_en = en_seq[i] | (i == 7);
            tick();
            total++;
            if (bus.dec_counter_out !== exp_seq[i]) begin
                bad++;
                $display("FAIL counter[%0d] rst=%b en=%b: got=%b required=%b",
                         i, rst, bus.counter_en, bus.dec_counter_out, exp_seq[i]);
            end
        end
        rst = 1'b0;
        bus.counter_en = 1'b1;
        tick();
        total++;
        if (bus.dec_counter_out !== 3'b111) begin
            bad++;
            $display("FAIL counter_resume: got=%b required=111", bus.dec_counter_out);
        end
        bus.counter_en = 1'b0;
    endtask

    task automatic test_decoder();
        bus.x = 3'b101;
        bus.en = 1'b1;
        tick();
        total++;
        if (bus.y_dec !== 8'b0010_0000) begin
            bad++;
            $display("FAIL dec_x5: got=%b required=00100000", bus.y_dec);
        end
        bus.en = 1'b0;
        tick();
        total++;
        if (bus.y_dec !== 8'b0000_0000) begin
            bad++;
            $display("FAIL dec_disabled: got=%b required=00000000", bus.y_dec);
        end
        bus.en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            logic [7:0] exp_y;
            exp_y = 8'b0000_0000;
            exp_y[i] = 1'b1;
            bus.x = 3'(i);
            tick();
            total++;
            if (bus.y_dec !== exp_y) begin
                bad++;
                $display("FAIL dec_sweep x=%0d: got=%b required=%b", i, bus.y_dec, exp_y);
            end
        end
        rst = 1'b1;
        bus.x = 3'b010;
        tick();
        total++;
        if (bus.y_dec !== 8'b0000_0000) begin
            bad++;
            $display("FAIL dec_rst_priority: got=%b required=00000000", bus.y_dec);
        end
        rst = 1'b0;
        tick();
        total++;
        if (bus.y_dec !== 8'b0000_0100) begin
            bad++;
            $display("FAIL dec_after_rst: got=%b required=00000100", bus.y_dec);
        end
        bus.en = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [2:0] ops  [4];
        logic [3:0] as   [4];
        logic [3:0] bs   [4];
        logic [3:0] ress [4];
        logic [2:0] cnts [4];
        ops  = '{3'b000, 3'b001, 3'b100, 3'b111};
        as   = '{4'b0010, 4'b0010, 4'b0001, 4'b1001};
        bs   = '{4'b0011, 4'b0011, 4'b0110, 4'b1001};
        ress = '{4'b0101, 4'b1111, 4'b0111, 4'b0001};
        cnts = '{3'b111, 3'b110, 3'b101, 3'b100};
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.counter_en = 1'b1;
        bus.en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            logic [7:0] exp_y;
            exp_y = 8'b0000_0000;
            exp_y[7 - i] = 1'b1;
            bus.alu_fnselec = ops[i];
            bus.alu_a = as[i];
            bus.alu_b = bs[i];
            bus.x = 3'(7 - i);
            tick();
            total++;
            if (bus.alu_res !== ress[i] || bus.dec_counter_out !== cnts[i] || bus.y_dec !== exp_y) begin
                bad++;
                $display("FAIL b2b[%0d]: res=%b cnt=%b y=%b required res=%b cnt=%b y=%b",
                         i, bus.alu_res, bus.dec_counter_out, bus.y_dec, ress[i], cnts[i], exp_y);
            end
        end
        bus.counter_en = 1'b0;
        bus.en = 1'b0;
    endtask

    initial begin
        total = 0;
        bad = 0;
        rst = 1'b1;
        bus.alu_fnselec = 3'b000;
        bus.alu_a = 4'b0000;
        bus.alu_b = 4'b0000;
        bus.counter_en = 1'b0;
        bus.x = 3'b000;
        bus.en = 1'b0;
        test_reset();
        test_alu_arith();
        test_alu_logic_cmp();
        test_counter();
        test_decoder();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_cnt_dec_unit.md
ALU_CNT_DEC_UNIT -- requirements
Module: alu_cnt_dec_unit

Interface
REQ-001 Parameters: none; all widths fixed (ALU 4 bit, counter 3 bit, decoder 3-to-8).
REQ-002 Clocking SHALL be one clock; reset is synchronous and active-high.
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 alu_fnselec  in  3  ALU opcode.
REQ-006 alu_a  in  4  operand A, two's complement.
REQ-007 alu_b  in  4  operand B, two's complement.
REQ-008 alu_res  out  4  registered ALU result.
REQ-009 alu_zero  out  1  registered; 1 when the alu_res value captured in the same cycle is 0000.
REQ-010 alu_overflow  out  1  registered signed-overflow flag.
REQ-011 alu_carry  out  1  registered carry-out flag.
REQ-012 counter_en  in  1  down-counter enable.
REQ-013 dec_counter_out  out  3  down-counter value.
REQ-014 x  in  3  decoder select.
REQ-015 en  in  1  decoder enable.
REQ-016 y_dec  out  8  registered one-hot decoder output.

Function
REQ-017 The ALU SHALL capture its result on every rising clk edge; latency is 1 cycle from operand/opcode change.
REQ-018 Opcode 000 (add): res = A+B mod 16, carry = bit 4 of the unsigned 5-bit sum, overflow = 1 when A and B have equal signs and res has a different sign.
REQ-019 Opcode 001 (sub): res = A + ~B + 1 mod 16, carry = bit 4 of that sum (1 when A >= B unsigned), overflow = 1 when A and B have different signs and res sign differs from A.
REQ-020 Opcode 010: res = ~A; 011: res = A & B; 100: res = A | B; 101: res = A ^ B.
REQ-021 Opcode 110 (signed less-than): res = 000 followed by a single bit that is 1 iff A < B signed.
REQ-022 Opcode 111 (equal): res = 000 followed by a single bit that is 1 iff A == B.
REQ-023 For opcodes 010-111, carry and overflow SHALL be 0.
REQ-024 alu_zero SHALL be computed from the result registered in the same cycle, for every opcode.
REQ-025 Counter: when counter_en = 1, dec_counter_out SHALL decrement by 1 each clk edge; 000 SHALL wrap to 111.
REQ-026 When counter_en = 0, the counter SHALL hold its value.
REQ-027 Decoder: on each clk edge, y_dec SHALL register bit x = 1 with all other bits 0 when en = 1, and 00000000 when en = 0.
REQ-028 The decoder SHALL have 1-cycle latency.

Reset
REQ-029 While rst = 1 at a clk edge: alu_res = 0000, alu_zero = 0, alu_overflow = 0, alu_carry = 0, dec_counter_out = 000, y_dec = 00000000.
REQ-030 rst SHALL take priority over counter_en and en.
REQ-031 On the first edge after rst deasserts, normal operation SHALL resume.
REQ-032 Asserting rst mid-count SHALL force the counter to 000 on that edge.

Structure
REQ-033 A shared package SHALL hold the 3-bit ALU opcode constants (ADD, SUB, NOT, AND, OR, XOR, SLT, EQ), plus widths ALU_W = 4 and CNT_W = 3.
REQ-034 The combinational ALU datapath SHALL be one sub-module, alu_4bit_core; the registers, counter and decoder SHALL stay in the top.

Verification
REQ-035 ADD: A = 0111, B = 0001 -> after 1 edge res = 1000, overflow = 1, carry = 0, zero = 0.
REQ-036 ADD: A = 1111, B = 0001 -> res = 0000, carry = 1, zero = 1, overflow = 0.
REQ-037 SUB: A = 1000, B = 0001 -> res = 0111, overflow = 1, carry = 1.
REQ-038 SLT and EQ: A = 1111, B = 0001 with op 110 -> res = 0001; op 111 with A = B = 0101 -> res = 0001, zero = 0.
REQ-039 Counter: rst, then counter_en = 1 for 3 edges -> 111, 110, 101; counter_en = 0 -> holds 101; rst mid-count -> 000.
REQ-040 Decoder: x = 101, en = 1 -> y_dec = 00100000 after 1 edge; en = 0 -> 00000000; sweep x = 000..111 for one-hot coverage.
